// File: rtl/cache_wb_buffer_pkg.sv
// cache_wb_buffer_pkg: geometry shared by the writeback buffer, its FIFO and its interface.
package cache_wb_buffer_pkg;
    localparam int PA_BITS = 32;
    localparam int LINELEN = 256;
    localparam int BEATLEN = 64;
    localparam int DEPTH = 2;
    localparam int OFFSETLEN = $clog2(LINELEN / 8);
endpackage

// File: rtl/cache_wb_buffer_if.sv
// cache_wb_buffer_if: victim-line push, bus burst and refill-lookup signals of the writeback buffer.
interface cache_wb_buffer_if;
    import cache_wb_buffer_pkg::*;
    logic               WBValid;
    logic               WBReady;
    logic [PA_BITS-1:0] WBAdr;
    logic [LINELEN-1:0] WBLine;
    logic               BusValid;
    logic               BusReady;
    logic [PA_BITS-1:0] BusAdr;
    logic [BEATLEN-1:0] BusData;
    logic               BusFirst;
    logic               BusLast;
    logic [PA_BITS-1:0] LookupAdr;
    logic               LookupHit;
    logic               Empty;
    modport slave (
        input  WBValid, WBAdr, WBLine, BusReady, LookupAdr,
        output WBReady, BusValid, BusAdr, BusData, BusFirst, BusLast, LookupHit, Empty
    );
    modport master (
        output WBValid, WBAdr, WBLine, BusReady, LookupAdr,
        input  WBReady, BusValid, BusAdr, BusData, BusFirst, BusLast, LookupHit, Empty
    );
endinterface

// File: rtl/cache_wb_fifo.sv
// cache_wb_fifo: circular store of victim lines with tags and per-entry valid bits for hazard lookup.
module cache_wb_fifo import cache_wb_buffer_pkg::*; #(
    parameter int ENTRIES = DEPTH,
    parameter int TAGW = PA_BITS - OFFSETLEN,
    parameter int LINEW = LINELEN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [TAGW-1:0]               pushTag,
    input  logic [LINEW-1:0]              pushLine,
    output logic [TAGW-1:0]               headTag,
    output logic [LINEW-1:0]              headLine,
    output logic [ENTRIES-1:0][TAGW-1:0]  tags,
    output logic [ENTRIES-1:0]            valids,
    output logic [$clog2(ENTRIES):0]      count,
    output logic                          full,
    output logic                          empty
);
    localparam int PW = $clog2(ENTRIES);
    localparam int CW = PW + 1;
    logic [PW-1:0] wrPtr, rdPtr;
    logic [ENTRIES-1:0][LINEW-1:0] lines;
    // Pointers wrap naturally because ENTRIES is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            valids <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (pop) valids[rdPtr] <= 1'b0;
            if (push) valids[wrPtr] <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            tags[wrPtr] <= pushTag;
            lines[wrPtr] <= pushLine;
        end
    end
    assign headTag = tags[rdPtr];
    assign headLine = lines[rdPtr];
    assign full = count == CW'(ENTRIES);
    assign empty = count == '0;
endmodule

// File: rtl/cache_wb_buffer.sv
// cache_wb_buffer: queues dirty victim lines from the D$ and drains each as a beat burst to the bus,
// flagging refills that hit a line still waiting to be written back.
module cache_wb_buffer import cache_wb_buffer_pkg::*; (
    input logic clk,
    input logic reset,
    cache_wb_buffer_if.slave wb
);
    localparam int BEATS = LINELEN / BEATLEN;
    localparam int BEATBITS = $clog2(BEATS);
    localparam int BYTEBITS = $clog2(BEATLEN / 8);
    localparam int TAGW = PA_BITS - OFFSETLEN;
    localparam int CW = $clog2(DEPTH) + 1;
    typedef enum logic {IDLE, BURST} stateT;
    stateT state, nextState;
    logic [BEATBITS-1:0] beatCnt;
    logic push, pop, full, empty, beatAcc, lastBeat;
    logic [CW-1:0] count;
    logic [TAGW-1:0] headTag;
    logic [LINELEN-1:0] headLine;
    logic [BEATS-1:0][BEATLEN-1:0] headBeats;
    logic [DEPTH-1:0][TAGW-1:0] tags;
    logic [DEPTH-1:0] valids;
    logic unusedBits;

    assign push = wb.WBValid & ~full;
    assign beatAcc = wb.BusValid & wb.BusReady;
    assign lastBeat = beatCnt == BEATBITS'(BEATS - 1);
    assign pop = beatAcc & lastBeat;
    assign headBeats = headLine;
    assign unusedBits = ^{wb.WBAdr[OFFSETLEN-1:0], wb.LookupAdr[OFFSETLEN-1:0]};

    cache_wb_fifo fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .pushTag(wb.WBAdr[PA_BITS-1:OFFSETLEN]), .pushLine(wb.WBLine),
        .headTag(headTag), .headLine(headLine), .tags(tags), .valids(valids),
        .count(count), .full(full), .empty(empty)
    );

    always_ff @(posedge clk) state <= reset ? IDLE : nextState;

    // Stay in BURST across a line boundary when another line is already queued, so no bubble.
    always_comb
        nextState = state == IDLE ? (empty ? IDLE : BURST) : (pop && count == CW'(1) ? IDLE : BURST);

    always_ff @(posedge clk) begin
        if (reset) beatCnt <= '0;
        else if (beatAcc) beatCnt <= beatCnt + 1'b1;
    end

    always_comb begin
        wb.BusValid = state == BURST;
        wb.BusFirst = beatCnt == '0;
        wb.BusLast = lastBeat;
        wb.BusAdr = wb.BusValid ? {headTag, beatCnt, BYTEBITS'(0)} : '0;
        wb.BusData = wb.BusValid ? headBeats[beatCnt] : '0;
        wb.WBReady = ~full;
        wb.Empty = empty;
    end

    // The head stays valid through the cycle its last beat is accepted.
    always_comb begin
        wb.LookupHit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            wb.LookupHit |= valids[i] && tags[i] == wb.LookupAdr[PA_BITS-1:OFFSETLEN];
    end
endmodule

// File: tb/tb_cache_wb_buffer.sv
// tb_cache_wb_buffer: directed bursts, stalls, full-queue back-pressure, hazard lookup and mid-burst reset.
module tb_cache_wb_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int nAsserts = 0;
    int nFails = 0;
    cache_wb_buffer_if wbIf ();
    cache_wb_buffer dut (.clk(clk), .reset(reset), .wb(wbIf));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [31:0] adr, input logic [63:0] data,
                        input logic first, input logic last);
        chk({tag, ".valid"}, 64'(wbIf.BusValid), 64'd1);
        chk({tag, ".adr"}, 64'(wbIf.BusAdr), 64'(adr));
        chk({tag, ".data"}, wbIf.BusData, data);
        chk({tag, ".first"}, 64'(wbIf.BusFirst), 64'(first));
        chk({tag, ".last"}, 64'(wbIf.BusLast), 64'(last));
    endtask

    initial begin
        wbIf.WBValid = 1'b0;
        wbIf.WBAdr = '0;
        wbIf.WBLine = '0;
        wbIf.BusReady = 1'b0;
        wbIf.LookupAdr = '0;
        tick;
        tick;
        chk("rst.valid", 64'(wbIf.BusValid), 64'd0);
        chk("rst.first", 64'(wbIf.BusFirst), 64'd1);
        chk("rst.last", 64'(wbIf.BusLast), 64'd0);
        chk("rst.ready", 64'(wbIf.WBReady), 64'd1);
        chk("rst.empty", 64'(wbIf.Empty), 64'd1);
        chk("rst.hit", 64'(wbIf.LookupHit), 64'd0);
        chk("rst.adr", 64'(wbIf.BusAdr), 64'd0);
        chk("rst.data", wbIf.BusData, 64'd0);
        reset = 1'b0;

        // single line, bus always ready
        wbIf.WBValid = 1'b1;
        wbIf.WBAdr = 32'h8000_0040;
        wbIf.WBLine = {64'h4, 64'h3, 64'h2, 64'h1};
        wbIf.BusReady = 1'b1;
        #1 chk("t1.wbready", 64'(wbIf.WBReady), 64'd1);
        tick;
        wbIf.WBValid = 1'b0;
        #1 chk("t1.idle", 64'(wbIf.BusValid), 64'd0);
        chk("t1.notempty", 64'(wbIf.Empty), 64'd0);
        tick;
        wbIf.LookupAdr = 32'h8000_005C;
        #1 beat("t1.b0", 32'h8000_0040, 64'h1, 1'b1, 1'b0);
        chk("t1.hitin", 64'(wbIf.LookupHit), 64'd1);
        wbIf.LookupAdr = 32'h8000_0060;
        #1 chk("t1.hitout", 64'(wbIf.LookupHit), 64'd0);
        tick;
        beat("t1.b1", 32'h8000_0048, 64'h2, 1'b0, 1'b0);
        tick;
        beat("t1.b2", 32'h8000_0050, 64'h3, 1'b0, 1'b0);
        tick;
        wbIf.LookupAdr = 32'h8000_0040;
        #1 beat("t1.b3", 32'h8000_0058, 64'h4, 1'b0, 1'b1);
        chk("t1.hitlast", 64'(wbIf.LookupHit), 64'd1);
        tick;
        chk("t1.empty", 64'(wbIf.Empty), 64'd1);
        chk("t1.done", 64'(wbIf.BusValid), 64'd0);
        chk("t1.hitgone", 64'(wbIf.LookupHit), 64'd0);

        // stall during beat 1; offset bits of WBAdr are ignored
        wbIf.WBValid = 1'b1;
        wbIf.WBAdr = 32'h8000_101C;
        wbIf.WBLine = {64'h44, 64'h33, 64'h22, 64'h11};
        tick;
        wbIf.WBValid = 1'b0;
        tick;
        beat("t2.b0", 32'h8000_1000, 64'h11, 1'b1, 1'b0);
        tick;
        wbIf.BusReady = 1'b0;
        #1 beat("t2.b1", 32'h8000_1008, 64'h22, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            beat("t2.hold", 32'h8000_1008, 64'h22, 1'b0, 1'b0);
        end
        wbIf.BusReady = 1'b1;
        tick;
        beat("t2.b2", 32'h8000_1010, 64'h33, 1'b0, 1'b0);
        tick;
        beat("t2.b3", 32'h8000_1018, 64'h44, 1'b0, 1'b1);
        tick;
        chk("t2.empty", 64'(wbIf.Empty), 64'd1);

        // fill the queue while the bus stalls, then drain back-to-back
        wbIf.BusReady = 1'b0;
        wbIf.WBValid = 1'b1;
        wbIf.WBAdr = 32'h8000_2000;
        wbIf.WBLine = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
        #1 chk("t3.rdyC", 64'(wbIf.WBReady), 64'd1);
        tick;
        wbIf.WBAdr = 32'h8000_2020;
        wbIf.WBLine = {64'hD4, 64'hD3, 64'hD2, 64'hD1};
        #1 chk("t3.rdyD", 64'(wbIf.WBReady), 64'd1);
        tick;
        wbIf.WBAdr = 32'h8000_3040;
        wbIf.WBLine = {64'hE4, 64'hE3, 64'hE2, 64'hE1};
        wbIf.LookupAdr = 32'h8000_2030;
        #1 chk("t3.full", 64'(wbIf.WBReady), 64'd0);
        chk("t3.hitsecond", 64'(wbIf.LookupHit), 64'd1);
        beat("t3.C0stall", 32'h8000_2000, 64'hC1, 1'b1, 1'b0);
        wbIf.BusReady = 1'b1;
        tick;
        chk("t3.fullC1", 64'(wbIf.WBReady), 64'd0);
        beat("t3.C1", 32'h8000_2008, 64'hC2, 1'b0, 1'b0);
        tick;
        beat("t3.C2", 32'h8000_2010, 64'hC3, 1'b0, 1'b0);
        tick;
        beat("t3.C3", 32'h8000_2018, 64'hC4, 1'b0, 1'b1);
        chk("t3.fullC3", 64'(wbIf.WBReady), 64'd0);
        tick;
        chk("t3.rdyE", 64'(wbIf.WBReady), 64'd1);
        beat("t3.D0", 32'h8000_2020, 64'hD1, 1'b1, 1'b0);
        tick;
        wbIf.WBValid = 1'b0;
        #1 beat("t3.D1", 32'h8000_2028, 64'hD2, 1'b0, 1'b0);
        tick;
        beat("t3.D2", 32'h8000_2030, 64'hD3, 1'b0, 1'b0);
        tick;
        beat("t3.D3", 32'h8000_2038, 64'hD4, 1'b0, 1'b1);
        tick;
        beat("t3.E0", 32'h8000_3040, 64'hE1, 1'b1, 1'b0);
        tick;
        beat("t3.E1", 32'h8000_3048, 64'hE2, 1'b0, 1'b0);
        tick;
        beat("t3.E2", 32'h8000_3050, 64'hE3, 1'b0, 1'b0);
        tick;
        beat("t3.E3", 32'h8000_3058, 64'hE4, 1'b0, 1'b1);
        tick;
        chk("t3.empty", 64'(wbIf.Empty), 64'd1);
        chk("t3.done", 64'(wbIf.BusValid), 64'd0);

        // reset in the middle of a burst drops the line
        wbIf.WBValid = 1'b1;
        wbIf.WBAdr = 32'h8000_4000;
        wbIf.WBLine = {64'hF4, 64'hF3, 64'hF2, 64'hF1};
        tick;
        wbIf.WBValid = 1'b0;
        tick;
        tick;
        tick;
        wbIf.LookupAdr = 32'h8000_4000;
        #1 beat("t6.b2", 32'h8000_4010, 64'hF3, 1'b0, 1'b0);
        chk("t6.hit", 64'(wbIf.LookupHit), 64'd1);
        reset = 1'b1;
        tick;
        chk("t6.valid", 64'(wbIf.BusValid), 64'd0);
        chk("t6.empty", 64'(wbIf.Empty), 64'd1);
        chk("t6.ready", 64'(wbIf.WBReady), 64'd1);
        chk("t6.hit0", 64'(wbIf.LookupHit), 64'd0);
        chk("t6.first", 64'(wbIf.BusFirst), 64'd1);
        reset = 1'b0;
        tick;
        chk("t6.stillidle", 64'(wbIf.BusValid), 64'd0);
        chk("t6.stillempty", 64'(wbIf.Empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
